// File: rtl/fft_spi_tx.sv
// fft_spi_tx: streams FFT result words to an SPI slave (mode 0, MSB first) in fixed-length cs_n frames.
// Optional feature: define FFT_SPI_TX_HEADER_EN to prepend an 0xA5-pattern sync word to every frame.
module fft_spi_tx #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned FRAME_WORDS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic              frame_done,
   output logic              underrun
);

`ifdef FFT_SPI_TX_HEADER_EN
   localparam int unsigned HDR_WORDS = 1;
   localparam logic [DATA_W-1:0] SYNC_WORD = DATA_W'({((DATA_W + 7) / 8){8'hA5}});
`else
   localparam int unsigned HDR_WORDS = 0;
`endif
   localparam int unsigned TOTAL_WORDS = FRAME_WORDS + HDR_WORDS;
   localparam int unsigned DIV_W       = $clog2(CLK_DIV + 1);
   localparam int unsigned BIT_W       = $clog2(DATA_W + 1);
   localparam int unsigned WORD_W      = $clog2(TOTAL_WORDS + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      STALL = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t state, state_nxt, prev_state;

   logic [DATA_W-1:0] hold;
   logic              hold_full;
   logic              rdy_en;
   logic [DATA_W-1:0] sh;
   logic [DIV_W-1:0]  div_cnt;
   logic              phase;
   logic [BIT_W-1:0]  bit_cnt;
   logic [WORD_W-1:0] word_cnt;

   logic              accept;
   logic              div_end;
   logic              last_bit;
   logic              last_word;
   logic              word_end;
   logic              load_hold;
   logic [DATA_W-1:0] first_word;

   logic sclk_c, mosi_c, cs_n_c, frame_done_c, underrun_c;

   assign din_ready = rdy_en && !hold_full;
   assign accept    = din_valid && din_ready;
   assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));
   assign last_word = (word_cnt == WORD_W'(TOTAL_WORDS - 1));
   assign word_end  = (state == SHIFT) && phase && div_end && last_bit;

`ifdef FFT_SPI_TX_HEADER_EN
   assign first_word = SYNC_WORD;
`else
   assign first_word = hold;
`endif

   // State register; prev_state lets the output logic detect state entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         prev_state <= IDLE;
      end else begin
         state      <= state_nxt;
         prev_state <= state;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hold_full) state_nxt = SHIFT;
         SHIFT: begin
            if (word_end) begin
               if (last_word)      state_nxt = HOLD;
               else if (hold_full) state_nxt = SHIFT;
               else                state_nxt = STALL;
            end
         end
         STALL:   if (hold_full) state_nxt = SHIFT;
         HOLD:    if (div_end) state_nxt = GAP;
         GAP:     if (div_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Hold slot is consumed whenever its word moves into the shifter.
   always_comb begin
      load_hold = 1'b0;
      case (state)
`ifdef FFT_SPI_TX_HEADER_EN
         IDLE:    load_hold = 1'b0;
`else
         IDLE:    load_hold = hold_full;
`endif
         SHIFT:   load_hold = hold_full && word_end && !last_word;
         STALL:   load_hold = hold_full;
         default: load_hold = 1'b0;
      endcase
   end

   // Single-entry holding register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= '0;
         hold_full <= 1'b0;
         rdy_en    <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (load_hold) begin
            hold_full <= 1'b0;
         end else if (accept) begin
            hold      <= din;
            hold_full <= 1'b1;
         end
      end
   end

   // Shifter and bit/word timing counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh       <= '0;
         div_cnt  <= '0;
         phase    <= 1'b0;
         bit_cnt  <= '0;
         word_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               div_cnt  <= '0;
               phase    <= 1'b0;
               bit_cnt  <= '0;
               word_cnt <= '0;
               if (hold_full) sh <= first_word;
            end
            SHIFT: begin
               if (div_end) begin
                  div_cnt <= '0;
                  phase   <= ~phase;
                  if (phase) begin
                     if (last_bit) begin
                        bit_cnt  <= '0;
                        word_cnt <= last_word ? '0 : word_cnt + WORD_W'(1);
                        if (load_hold) sh <= hold;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        sh      <= {sh[DATA_W-2:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            STALL: begin
               if (hold_full) sh <= hold;
            end
            HOLD, GAP: begin
               div_cnt <= div_end ? '0 : div_cnt + DIV_W'(1);
            end
            default: begin
               div_cnt <= '0;
            end
         endcase
      end
   end

   // Output decode from the current state.
   always_comb begin
      sclk_c       = 1'b0;
      cs_n_c       = 1'b1;
      mosi_c       = sh[DATA_W-1];
      frame_done_c = 1'b0;
      underrun_c   = 1'b0;
      case (state)
         SHIFT: begin
            sclk_c = phase;
            cs_n_c = 1'b0;
         end
         STALL: begin
            cs_n_c     = 1'b0;
            underrun_c = (prev_state != STALL);
         end
         HOLD: begin
            cs_n_c = 1'b0;
         end
         GAP: begin
            frame_done_c = (prev_state != GAP);
         end
         default: begin
            cs_n_c = 1'b1;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         cs_n       <= 1'b1;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         sclk       <= sclk_c;
         mosi       <= mosi_c;
         cs_n       <= cs_n_c;
         frame_done <= frame_done_c;
         underrun   <= underrun_c;
      end
   end

endmodule

// File: tb/tb_fft_spi_tx.sv
// Directed testbench for fft_spi_tx (CLK_DIV=2, FRAME_WORDS=4); honours FFT_SPI_TX_HEADER_EN if defined.
module tb_fft_spi_tx;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned CLK_DIV     = 2;
   localparam int unsigned FRAME_WORDS = 4;
`ifdef FFT_SPI_TX_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int NW       = FRAME_WORDS + HDR;
   localparam int BIT_CYC  = 2 * CLK_DIV;
   localparam logic [15:0] SYNC = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready, sclk, mosi, cs_n, frame_done, underrun;

   int total = 0;
   int bad   = 0;

   fft_spi_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .FRAME_WORDS(FRAME_WORDS)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .frame_done(frame_done), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // Bus monitor: reassembles words from mosi on sclk rises and keeps running event counts.
   int          rises = 0, cs_low = 0, fd_cnt = 0, ur_cnt = 0, bitn = 0;
   logic [15:0] shreg = '0;
   logic [15:0] words[$];
   logic        prev_sclk = 1'b0, prev_cs_n = 1'b1, rise_pending = 1'b0;
   time         t_cs_fall = 0, t_first_rise = 0, t_accept = 0;

   always @(negedge clk) begin
      if (rst) begin
         bitn = 0;
      end else begin
         if (!cs_n && prev_cs_n) begin
            t_cs_fall    = $time - 5;
            rise_pending = 1'b1;
            bitn         = 0;
         end
         if (sclk && !prev_sclk) begin
            rises++;
            shreg = {shreg[14:0], mosi};
            bitn++;
            if (rise_pending) begin
               t_first_rise = $time - 5;
               rise_pending = 1'b0;
            end
            if (bitn == 16) begin
               words.push_back(shreg);
               bitn = 0;
            end
         end
         if (!cs_n)      cs_low++;
         if (frame_done) fd_cnt++;
         if (underrun)   ur_cnt++;
      end
      prev_sclk = sclk;
      prev_cs_n = cs_n;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] w);
      int n = 0;
      din       = w;
      din_valid = 1'b1;
      while (!din_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!din_ready) begin
         total++; bad++;
         $display("FAIL send_word_timeout word=%h din_ready=%b required=1", w, din_ready);
      end
      @(posedge clk);
      t_accept = $time;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic wait_words(input int n_words);
      int n = 0;
      while (words.size() < n_words && n < 5000) begin
         tick();
         n++;
      end
      if (words.size() < n_words) begin
         total++; bad++;
         $display("FAIL wait_words_timeout got=%0d required=%0d", words.size(), n_words);
      end
   endtask

   task automatic wait_fd(input int fd_base);
      int n = 0;
      while (fd_cnt == fd_base && n < 5000) begin
         tick();
         n++;
      end
      if (fd_cnt == fd_base) begin
         total++; bad++;
         $display("FAIL wait_frame_done_timeout frame_done_count=%0d required>%0d", fd_cnt, fd_base);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; din = '0; din_valid = 1'b0;
      repeat (3) tick();
      total++; if (cs_n !== 1'b1)       begin bad++; $display("FAIL reset_cs_n got=%b required=1", cs_n); end
      total++; if (sclk !== 1'b0)       begin bad++; $display("FAIL reset_sclk got=%b required=0", sclk); end
      total++; if (mosi !== 1'b0)       begin bad++; $display("FAIL reset_mosi got=%b required=0", mosi); end
      total++; if (din_ready !== 1'b0)  begin bad++; $display("FAIL reset_din_ready got=%b required=0", din_ready); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b required=0", frame_done); end
      total++; if (underrun !== 1'b0)   begin bad++; $display("FAIL reset_underrun got=%b required=0", underrun); end
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++; if (din_ready !== 1'b1)  begin bad++; $display("FAIL reset_release_ready got=%b required=1", din_ready); end
      tick();
   endtask

   task automatic test_single();
      int base = words.size();
      int fdb  = fd_cnt;
      logic [15:0] exp[$];
      if (HDR == 1) exp.push_back(SYNC);
      exp.push_back(16'hA5C3); exp.push_back(16'h0101); exp.push_back(16'h0202); exp.push_back(16'h0303);
      send_word(16'hA5C3);
      wait_words(base + HDR + 1);
      total++; if (int'(t_cs_fall - t_accept) != 20)
         begin bad++; $display("FAIL single_cs_latency got=%0d required=20", int'(t_cs_fall - t_accept)); end
      total++; if (int'(t_first_rise - t_cs_fall) != 20)
         begin bad++; $display("FAIL single_first_rise got=%0d required=20", int'(t_first_rise - t_cs_fall)); end
      total++; if (words.size() <= base + HDR || words[base + HDR] !== 16'hA5C3)
         begin bad++; $display("FAIL single_word got=%h required=a5c3", (words.size() > base + HDR) ? words[base + HDR] : 16'hxxxx); end
      send_word(16'h0101); send_word(16'h0202); send_word(16'h0303);
      wait_fd(fdb);
      total++; if (words.size() != base + NW)
         begin bad++; $display("FAIL single_frame_len got=%0d required=%0d", words.size() - base, NW); end
      for (int i = 0; i < NW && base + i < words.size(); i++) begin
         total++; if (words[base + i] !== exp[i])
            begin bad++; $display("FAIL single_frame_word%0d got=%h required=%h", i, words[base + i], exp[i]); end
      end
   endtask

   task automatic test_stream();
      int base = words.size();
      int fdb = fd_cnt, rb = rises, cb = cs_low, ub = ur_cnt;
      logic [15:0] exp[$];
      if (HDR == 1) exp.push_back(SYNC);
      exp.push_back(16'h1357); exp.push_back(16'hFFFF); exp.push_back(16'h0000); exp.push_back(16'h8001);
      send_word(16'h1357); send_word(16'hFFFF); send_word(16'h0000); send_word(16'h8001);
      wait_fd(fdb);
      tick();
      total++; if (rises - rb != NW * 16)
         begin bad++; $display("FAIL stream_sclk_pulses got=%0d required=%0d", rises - rb, NW * 16); end
      total++; if (cs_low - cb != NW * 16 * BIT_CYC + CLK_DIV)
         begin bad++; $display("FAIL stream_cs_low got=%0d required=%0d", cs_low - cb, NW * 16 * BIT_CYC + CLK_DIV); end
      total++; if (fd_cnt - fdb != 1)
         begin bad++; $display("FAIL stream_frame_done got=%0d required=1", fd_cnt - fdb); end
      total++; if (ur_cnt - ub != 0)
         begin bad++; $display("FAIL stream_underrun got=%0d required=0", ur_cnt - ub); end
      for (int i = 0; i < NW; i++) begin
         total++; if (base + i >= words.size() || words[base + i] !== exp[i])
            begin bad++; $display("FAIL stream_word%0d got=%h required=%h", i, (base + i < words.size()) ? words[base + i] : 16'hxxxx, exp[i]); end
      end
   endtask

   task automatic test_stall();
      int base = words.size();
      int fdb = fd_cnt, rb = rises, ub = ur_cnt;
      logic [15:0] exp[$];
      if (HDR == 1) exp.push_back(SYNC);
      exp.push_back(16'h1111); exp.push_back(16'h2223); exp.push_back(16'h3333); exp.push_back(16'h4444);
      send_word(16'h1111); send_word(16'h2223);
      wait_words(base + HDR + 2);
      repeat (20) tick();
      total++; if (sclk !== 1'b0) begin bad++; $display("FAIL stall_sclk got=%b required=0", sclk); end
      total++; if (cs_n !== 1'b0) begin bad++; $display("FAIL stall_cs_n got=%b required=0", cs_n); end
      total++; if (mosi !== 1'b1) begin bad++; $display("FAIL stall_mosi got=%b required=1", mosi); end
      total++; if (ur_cnt - ub != 1) begin bad++; $display("FAIL stall_underrun got=%0d required=1", ur_cnt - ub); end
      send_word(16'h3333); send_word(16'h4444);
      wait_fd(fdb);
      total++; if (ur_cnt - ub != 1) begin bad++; $display("FAIL stall_underrun_total got=%0d required=1", ur_cnt - ub); end
      total++; if (rises - rb != NW * 16)
         begin bad++; $display("FAIL stall_sclk_pulses got=%0d required=%0d", rises - rb, NW * 16); end
      total++; if (fd_cnt - fdb != 1) begin bad++; $display("FAIL stall_frame_done got=%0d required=1", fd_cnt - fdb); end
      for (int i = 0; i < NW; i++) begin
         total++; if (base + i >= words.size() || words[base + i] !== exp[i])
            begin bad++; $display("FAIL stall_word%0d got=%h required=%h", i, (base + i < words.size()) ? words[base + i] : 16'hxxxx, exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int base = words.size();
      int fdb = fd_cnt;
      int n = 0;
      int base2;
      logic [15:0] exp[$];
      send_word(16'hC001); send_word(16'h0E0F); send_word(16'h5A5A);
      while (!(words.size() >= base + HDR + 2 && bitn == 7) && n < 5000) begin
         tick();
         n++;
      end
      total++; if (bitn != 7) begin bad++; $display("FAIL rstmid_reach_bit7 got=%0d required=7", bitn); end
      rst = 1'b1;
      #1;
      total++; if (cs_n !== 1'b1)      begin bad++; $display("FAIL rstmid_cs_n got=%b required=1", cs_n); end
      total++; if (sclk !== 1'b0)      begin bad++; $display("FAIL rstmid_sclk got=%b required=0", sclk); end
      total++; if (mosi !== 1'b0)      begin bad++; $display("FAIL rstmid_mosi got=%b required=0", mosi); end
      total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL rstmid_din_ready got=%b required=0", din_ready); end
      tick();
      rst = 1'b0;
      tick();
      base2 = words.size();
      if (HDR == 1) exp.push_back(SYNC);
      exp.push_back(16'h0F0F); exp.push_back(16'hF0F0); exp.push_back(16'h00FF); exp.push_back(16'hFF00);
      send_word(16'h0F0F); send_word(16'hF0F0); send_word(16'h00FF); send_word(16'hFF00);
      wait_fd(fdb);
      total++; if (fd_cnt - fdb != 1) begin bad++; $display("FAIL rstmid_frame_done got=%0d required=1", fd_cnt - fdb); end
      total++; if (words.size() - base2 != NW)
         begin bad++; $display("FAIL rstmid_frame_len got=%0d required=%0d", words.size() - base2, NW); end
      for (int i = 0; i < NW; i++) begin
         total++; if (base2 + i >= words.size() || words[base2 + i] !== exp[i])
            begin bad++; $display("FAIL rstmid_word%0d got=%h required=%h", i, (base2 + i < words.size()) ? words[base2 + i] : 16'hxxxx, exp[i]); end
      end
   endtask

   task automatic test_gap();
      int base = words.size();
      int fdb = fd_cnt;
      int hi, n;
      logic [15:0] exp[$];
      send_word(16'h1001); send_word(16'h1002); send_word(16'h1003); send_word(16'h1004);
      wait_fd(fdb);
      total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL gap_ready got=%b required=1", din_ready); end
      din = 16'hBEEF;
      din_valid = 1'b1;
      @(posedge clk);
      t_accept = $time;
      tick();
      din_valid = 1'b0;
      hi = 1;
      n  = 0;
      while (cs_n === 1'b1 && n < 50) begin
         hi++;
         tick();
         n++;
      end
      total++; if (hi != CLK_DIV + 1) begin bad++; $display("FAIL gap_cs_high got=%0d required=%0d", hi, CLK_DIV + 1); end
      total++; if (int'(t_cs_fall - t_accept) != 20)
         begin bad++; $display("FAIL gap_cs_latency got=%0d required=20", int'(t_cs_fall - t_accept)); end
      send_word(16'h2002); send_word(16'h2003); send_word(16'h2004);
      wait_fd(fdb + 1);
      for (int f = 0; f < 2; f++) begin
         if (HDR == 1) exp.push_back(SYNC);
         if (f == 0) begin
            exp.push_back(16'h1001); exp.push_back(16'h1002); exp.push_back(16'h1003); exp.push_back(16'h1004);
         end else begin
            exp.push_back(16'hBEEF); exp.push_back(16'h2002); exp.push_back(16'h2003); exp.push_back(16'h2004);
         end
      end
      for (int i = 0; i < 2 * NW; i++) begin
         total++; if (base + i >= words.size() || words[base + i] !== exp[i])
            begin bad++; $display("FAIL gap_word%0d got=%h required=%h", i, (base + i < words.size()) ? words[base + i] : 16'hxxxx, exp[i]); end
      end
   endtask

   initial begin
      din       = '0;
      din_valid = 1'b0;
      rst       = 1'b1;
      test_reset();
      test_single();
      test_stream();
      test_stall();
      test_reset_mid();
      test_gap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout time=%0t required=finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
